// File: rtl/y86_prog_loader.sv
// Streams program bytes into 64-bit instruction-memory words and holds the
// Y86 core in reset until a complete program has been written.
module y86_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [63:0]       imem_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o,
  output logic [1:0]        state_o
);

  // Byte stream handshake: a byte moves when byte_valid_i & byte_ready_o are
  // both high at a rising edge; ready is high for the whole of LOAD and never
  // stalls for word writes, and valid may rise or fall without waiting.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   WORDS_ONE = 1;

  state_t            state;
  logic [2:0]        lane;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W:0]   words;
  logic [63:0]       asm_buf;
  logic [63:0]       merged;
  logic              hs;
  logic              overflow;
  logic              word_done;

  assign hs        = byte_valid_i & byte_ready_o;
  assign overflow  = words[ADDR_W];
  assign word_done = (lane == 3'd7) | byte_last_i;

  always_comb begin
    merged = asm_buf;
    merged[{lane, 3'b000} +: 8] = byte_data_i;
  end

  // Status outputs are pure decodes of the registered state.
  assign byte_ready_o = (state == S_LOAD);
  assign busy_o       = (state == S_LOAD);
  assign done_o       = (state == S_RUN);
  assign cpu_rst_n_o  = (state == S_RUN);
  assign err_o        = (state == S_ERR);
  assign words_o      = words;
  assign state_o      = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      lane         <= '0;
      word_addr    <= '0;
      words        <= '0;
      asm_buf      <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
    end else begin
      imem_we_o <= 1'b0;
      case (state)
        S_LOAD: begin
          if (hs) begin
            if (overflow) begin
              // Memory already full: drop the byte rather than wrap the address.
              state <= S_ERR;
            end else begin
              asm_buf <= merged;
              lane    <= lane + 3'd1;
              if (word_done) begin
                imem_we_o    <= 1'b1;
                imem_addr_o  <= word_addr;
                imem_wdata_o <= merged;
                word_addr    <= word_addr + ADDR_ONE;
                words        <= words + WORDS_ONE;
                asm_buf      <= '0;
                if (byte_last_i) begin
                  state <= S_RUN;
                end
              end
            end
          end
        end
        default: begin
          // IDLE, RUN and ERR all (re)start a load the same way.
          if (start_i) begin
            state     <= S_LOAD;
            lane      <= '0;
            word_addr <= '0;
            words     <= '0;
            asm_buf   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_prog_loader.sv
// Bench for y86_prog_loader: a default-depth instance and a 4-word instance
// share one byte stream and are scored against a word-packing model.
module tb_y86_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;

  logic        b_ready, b_we, b_cpu_rst_n, b_busy, b_done, b_err;
  logic [9:0]  b_addr;
  logic [63:0] b_wdata;
  logic [10:0] b_words;
  logic [1:0]  b_state;

  logic        s_ready, s_we, s_cpu_rst_n, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [63:0] s_wdata;
  logic [2:0]  s_words;
  logic [1:0]  s_state;

  // Write record: {cpu_rst_n at the strobe, 10-bit address, data}
  logic [74:0] act_b_q[$];
  logic [74:0] act_s_q[$];
  logic [74:0] exp_b_q[$];
  logic [74:0] exp_s_q[$];
  logic [74:0] model_q[$];
  logic [7:0]  stim_q[$];

  int n_cmp;
  int n_bad;
  int ready_drops;

  y86_prog_loader #(.ADDR_W(10)) dut_big (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_last_i(byte_last),
    .byte_ready_o(b_ready), .imem_we_o(b_we), .imem_addr_o(b_addr),
    .imem_wdata_o(b_wdata), .cpu_rst_n_o(b_cpu_rst_n), .busy_o(b_busy),
    .done_o(b_done), .err_o(b_err), .words_o(b_words), .state_o(b_state)
  );

  y86_prog_loader #(.ADDR_W(2)) dut_small (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_last_i(byte_last),
    .byte_ready_o(s_ready), .imem_we_o(s_we), .imem_addr_o(s_addr),
    .imem_wdata_o(s_wdata), .cpu_rst_n_o(s_cpu_rst_n), .busy_o(s_busy),
    .done_o(s_done), .err_o(s_err), .words_o(s_words), .state_o(s_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (b_we) act_b_q.push_back({b_cpu_rst_n, b_addr, b_wdata});
    if (s_we) act_s_q.push_back({s_cpu_rst_n, 8'h00, s_addr, s_wdata});
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_queues();
    act_b_q.delete(); act_s_q.delete(); exp_b_q.delete(); exp_s_q.delete();
    ready_drops = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back, 1 = idle cycle between bytes, 2 = random idles
  task automatic send_bytes(input bit with_last, input int gap_mode);
    int idle;
    for (int i = 0; i < stim_q.size(); i++) begin
      idle = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      if (i == 0) idle = 0;
      repeat (idle) begin
        @(negedge clk);
        byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'($urandom);
        if (!b_ready) ready_drops++;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = stim_q[i];
      byte_last  = with_last && (i == stim_q.size() - 1);
      if (!b_ready) ready_drops++;
    end
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic make_stim(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  // ---------------- reference model ----------------
  // Bytes fill 8-byte words in order; a word is written when full or when it
  // holds the final byte of a terminated program. A byte arriving after
  // 'depth' words have been written is an overflow.
  task automatic model_load(input int depth, input bit with_last,
                            output int n_words, output bit err);
    int n, nchunks;
    logic [63:0] w;
    bit fin;
    model_q.delete();
    n = stim_q.size();
    nchunks = (n + 7) / 8;
    n_words = 0;
    err = 1'b0;
    for (int k = 0; k < nchunks; k++) begin
      if (k >= depth) begin
        err = 1'b1;
        break;
      end
      fin = with_last && (k == nchunks - 1);
      if (!fin && (k * 8 + 8 > n)) break;
      w = '0;
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < n) w[b*8 +: 8] = stim_q[k*8 + b];
      model_q.push_back({fin, 10'(k), w});
      n_words++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({b_ready, b_we, b_cpu_rst_n, b_busy, b_done, b_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000000",
               {b_ready, b_we, b_cpu_rst_n, b_busy, b_done, b_err});
    end
    n_cmp++;
    if ({b_addr, b_wdata, b_words} !== 85'b0) begin
      n_bad++;
      $display("FAIL reset_data: addr %h wdata %h words %h expected all zero", b_addr, b_wdata, b_words);
    end
    n_cmp++;
    if ({s_ready, s_we, s_cpu_rst_n, s_busy, s_done, s_err, s_words} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_small: got %b expected 0",
               {s_ready, s_we, s_cpu_rst_n, s_busy, s_done, s_err, s_words});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      byte_last  = 1'($urandom);
      n_cmp++;
      if ({b_ready, b_we, b_cpu_rst_n, b_busy, b_done, b_err, b_words} !== 17'b0) begin
        n_bad++;
        $display("FAIL idle_outputs cycle %0d: got %b expected 0", i,
                 {b_ready, b_we, b_cpu_rst_n, b_busy, b_done, b_err, b_words});
      end
    end
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0;
    n_cmp++;
    if (act_b_q.size() + act_s_q.size() != 0) begin
      n_bad++;
      $display("FAIL idle_writes: got %0d writes expected 0", act_b_q.size() + act_s_q.size());
    end
  endtask

  task automatic test_single_word();
    clear_queues();
    stim_q = '{8'h30, 8'hF0, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pulse_start();
    send_bytes(1'b1, 0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (act_b_q.size() != 1) begin
      n_bad++;
      $display("FAIL single_count: got %0d writes expected 1", act_b_q.size());
    end else begin
      n_cmp++;
      if (act_b_q[0] !== {1'b1, 10'd0, 64'h00000000000AF030}) begin
        n_bad++;
        $display("FAIL single_write: got %h expected %h", act_b_q[0], {1'b1, 10'd0, 64'h00000000000AF030});
      end
    end
    n_cmp++;
    if ({b_done, b_cpu_rst_n, b_busy, b_ready, b_words} !== {4'b1100, 11'd1}) begin
      n_bad++;
      $display("FAIL single_status: done/cpu/busy/ready/words got %b expected %b",
               {b_done, b_cpu_rst_n, b_busy, b_ready, b_words}, {4'b1100, 11'd1});
    end
  endtask

  task automatic test_two_words(input int gap_mode);
    logic [74:0] e0, e1;
    e0 = {1'b0, 10'd0, 64'h0807060504030201};
    e1 = {1'b1, 10'd1, 64'h00000000000B0A09};
    clear_queues();
    stim_q.delete();
    for (int i = 1; i <= 11; i++) stim_q.push_back(8'(i));
    pulse_start();
    send_bytes(1'b1, gap_mode);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (act_b_q.size() != 2) begin
      n_bad++;
      $display("FAIL two_count gap%0d: got %0d writes expected 2", gap_mode, act_b_q.size());
    end else begin
      n_cmp++;
      if (act_b_q[0] !== e0) begin
        n_bad++;
        $display("FAIL two_word0 gap%0d: got %h expected %h", gap_mode, act_b_q[0], e0);
      end
      n_cmp++;
      if (act_b_q[1] !== e1) begin
        n_bad++;
        $display("FAIL two_word1 gap%0d: got %h expected %h", gap_mode, act_b_q[1], e1);
      end
    end
    n_cmp++;
    if (b_words !== 11'd2 || b_done !== 1'b1) begin
      n_bad++;
      $display("FAIL two_status gap%0d: words %0d done %b expected 2 1", gap_mode, b_words, b_done);
    end
    n_cmp++;
    if (ready_drops != 0) begin
      n_bad++;
      $display("FAIL two_ready gap%0d: ready low on %0d load cycles expected 0", gap_mode, ready_drops);
    end
  endtask

  task automatic test_run_start_collision();
    logic [63:0] w;
    clear_queues();
    @(negedge clk);
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE; byte_last = 1'b1;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    n_cmp++;
    if ({b_busy, b_cpu_rst_n, b_done, b_words} !== {3'b100, 11'd0}) begin
      n_bad++;
      $display("FAIL collide_status: busy/cpu/done/words got %b expected %b",
               {b_busy, b_cpu_rst_n, b_done, b_words}, {3'b100, 11'd0});
    end
    make_stim(8);
    send_bytes(1'b1, 0);
    repeat (2) @(negedge clk);
    w = '0;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = stim_q[b];
    n_cmp++;
    if (act_b_q.size() != 1) begin
      n_bad++;
      $display("FAIL collide_count: got %0d writes expected 1", act_b_q.size());
    end else begin
      n_cmp++;
      if (act_b_q[0] !== {1'b1, 10'd0, w}) begin
        n_bad++;
        $display("FAIL collide_write: got %h expected %h", act_b_q[0], {1'b1, 10'd0, w});
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] w;
    clear_queues();
    make_stim(5);
    pulse_start();
    send_bytes(1'b0, 0);
    n_cmp++;
    if (b_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_busy_before: got %b expected 1", b_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_busy, b_ready, b_we, b_cpu_rst_n, b_addr, b_wdata, b_words} !== 89'b0) begin
      n_bad++;
      $display("FAIL midrst_async: busy %b ready %b we %b cpu %b addr %h wdata %h words %h expected all zero",
               b_busy, b_ready, b_we, b_cpu_rst_n, b_addr, b_wdata, b_words);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act_b_q.size() != 0 || b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: writes %0d busy %b expected 0 0", act_b_q.size(), b_busy);
    end
    make_stim(8);
    pulse_start();
    send_bytes(1'b1, 0);
    repeat (2) @(negedge clk);
    w = '0;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = stim_q[b];
    n_cmp++;
    if (act_b_q.size() != 1 || act_b_q[0] !== {1'b1, 10'd0, w}) begin
      n_bad++;
      $display("FAIL midrst_reload: writes %0d first %h expected 1 %h",
               act_b_q.size(), (act_b_q.size() > 0) ? act_b_q[0] : 75'b0, {1'b1, 10'd0, w});
    end
  endtask

  task automatic test_overflow();
    logic [63:0] w;
    apply_reset();
    clear_queues();
    make_stim(33);
    pulse_start();
    send_bytes(1'b0, 0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (act_s_q.size() != 4) begin
      n_bad++;
      $display("FAIL ovf_count: got %0d writes expected 4", act_s_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        w = '0;
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = stim_q[k*8 + b];
        n_cmp++;
        if (act_s_q[k] !== {1'b0, 8'h00, 2'(k), w}) begin
          n_bad++;
          $display("FAIL ovf_word%0d: got %h expected %h", k, act_s_q[k], {1'b0, 8'h00, 2'(k), w});
        end
      end
    end
    n_cmp++;
    if ({s_err, s_cpu_rst_n, s_ready, s_busy, s_words} !== {4'b1000, 3'd4}) begin
      n_bad++;
      $display("FAIL ovf_status: err/cpu/ready/busy/words got %b expected %b",
               {s_err, s_cpu_rst_n, s_ready, s_busy, s_words}, {4'b1000, 3'd4});
    end
    pulse_start();
    n_cmp++;
    if ({s_busy, s_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovf_restart: busy/err got %b expected 10", {s_busy, s_err});
    end
    n_cmp++;
    if ({b_busy, b_words} !== {1'b1, 11'd4}) begin
      n_bad++;
      $display("FAIL load_ignores_start: busy/words got %b expected %b", {b_busy, b_words}, {1'b1, 11'd4});
    end
    apply_reset();
  endtask

  task automatic test_random_reloads();
    int n_len, gap, nb, ns;
    bit wl, eb, es, need_reset;
    need_reset = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if (need_reset) apply_reset();
      clear_queues();
      n_len = $urandom_range(1, 40);
      wl    = ($urandom_range(0, 3) != 0);
      gap   = $urandom_range(0, 2);
      make_stim(n_len);
      model_load(1024, wl, nb, eb);
      exp_b_q = model_q;
      model_load(4, wl, ns, es);
      exp_s_q = model_q;
      pulse_start();
      send_bytes(wl, gap);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (act_b_q.size() != exp_b_q.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_big_count: got %0d writes expected %0d", it, act_b_q.size(), exp_b_q.size());
      end else begin
        foreach (exp_b_q[i]) begin
          n_cmp++;
          if (act_b_q[i] !== exp_b_q[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_big_write%0d: got %h expected %h", it, i, act_b_q[i], exp_b_q[i]);
          end
        end
      end
      n_cmp++;
      if (act_s_q.size() != exp_s_q.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_small_count: got %0d writes expected %0d", it, act_s_q.size(), exp_s_q.size());
      end else begin
        foreach (exp_s_q[i]) begin
          n_cmp++;
          if (act_s_q[i] !== exp_s_q[i]) begin
            n_bad++;
            $display("FAIL rnd%0d_small_write%0d: got %h expected %h", it, i, act_s_q[i], exp_s_q[i]);
          end
        end
      end
      n_cmp++;
      if ({b_busy, b_done, b_err, b_cpu_rst_n, b_words} !==
          {!eb && !wl, !eb && wl, eb, !eb && wl, 11'(nb)}) begin
        n_bad++;
        $display("FAIL rnd%0d_big_status: busy/done/err/cpu/words got %b expected %b", it,
                 {b_busy, b_done, b_err, b_cpu_rst_n, b_words},
                 {!eb && !wl, !eb && wl, eb, !eb && wl, 11'(nb)});
      end
      n_cmp++;
      if ({s_busy, s_done, s_err, s_cpu_rst_n, s_words} !==
          {!es && !wl, !es && wl, es, !es && wl, 3'(ns)}) begin
        n_bad++;
        $display("FAIL rnd%0d_small_status: busy/done/err/cpu/words got %b expected %b", it,
                 {s_busy, s_done, s_err, s_cpu_rst_n, s_words},
                 {!es && !wl, !es && wl, es, !es && wl, 3'(ns)});
      end
      n_cmp++;
      if (ready_drops != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_ready: ready low on %0d load cycles expected 0", it, ready_drops);
      end
      need_reset = !wl;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_bad = 0; ready_drops = 0;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    test_reset();
    test_single_word();
    test_two_words(0);
    test_two_words(1);
    test_run_start_collision();
    test_reset_mid_word();
    test_overflow();
    test_random_reloads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y86_prog_loader.md
Y86_PROG_LOADER -- requirements
Module: y86_prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction-memory depth exponent in 64-bit words (depth = 2^ADDR_W).
REQ-002 Clocking: one clock, clk_i; reset is asynchronous and active-low, rst_n_i.
REQ-003 clk_i  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n_i  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  single-cycle request to begin a program load.
REQ-006 byte_valid_i  input  1  program byte present on byte_data_i.
REQ-007 byte_data_i  input  8  program byte, in ascending program-address order.
REQ-008 byte_last_i  input  1  current byte is the final program byte; sampled only on a handshake.
REQ-009 byte_ready_o  output  1  loader accepts a byte; handshake = byte_valid_i & byte_ready_o at a rising edge.
REQ-010 imem_we_o  output  1  one-cycle instruction-memory word write strobe.
REQ-011 imem_addr_o  output  ADDR_W  word address of the write.
REQ-012 imem_wdata_o  output  64  write data, little-endian (byte 0 in bits 7:0).
REQ-013 cpu_rst_n_o  output  1  active-low reset to the CPU core; low while no valid program is loaded.
REQ-014 busy_o  output  1  high in LOAD state.
REQ-015 done_o  output  1  high in RUN state.
REQ-016 err_o  output  1  high in ERR state.
REQ-017 words_o  output  ADDR_W+1  count of words written in the current or last load.

Function
REQ-018 FSM states: IDLE, LOAD, RUN, ERR; all outputs are registered or decoded from the state only.
REQ-019 IDLE: byte_ready_o=0, cpu_rst_n_o=0; start_i -> LOAD.
REQ-020 LOAD entry: clears lane counter, word address and words_o to 0 and the assembly buffer to 0.
REQ-021 LOAD: byte_ready_o=1 continuously, with no back-pressure stalls for word writes.
REQ-022 Each handshake stores byte_data_i into buffer lane = lane counter (0..7); the lane counter increments mod 8.
REQ-023 A handshake on lane 7, or any handshake with byte_last_i=1, completes a word.
REQ-024 On a completed word, imem_we_o=1 for exactly the next cycle, with imem_addr_o = current word address and imem_wdata_o = the assembled word.
REQ-025 After a completed word, word address and words_o increment, and the buffer is cleared.
REQ-026 Lanes above the last byte of a final partial word are written as 0x00.
REQ-027 A byte_last_i handshake moves LOAD -> RUN at the same edge that raises imem_we_o.
REQ-028 RUN: cpu_rst_n_o=1 and done_o=1 from the cycle after that edge, so the CPU leaves reset coincident with the final write strobe.
REQ-029 Overflow: a handshake in LOAD when words_o = 2^ADDR_W is dropped (no write); the state moves to ERR.
REQ-030 ERR: byte_ready_o=0, cpu_rst_n_o=0, err_o=1.
REQ-031 In LOAD, start_i is ignored.
REQ-032 In RUN or ERR, start_i -> LOAD, and cpu_rst_n_o falls the following cycle (reload).
REQ-033 In IDLE, RUN and ERR, byte_valid_i is ignored and no write occurs.
REQ-034 Simultaneous start_i and byte_valid_i in RUN: the start is taken and the byte is not consumed (ready=0 that cycle).
REQ-035 A completed word at address 2^ADDR_W-1 is written normally; overflow is detected only on the next handshake.

Reset
REQ-036 On rst_n_i low, immediately and independent of clk_i: state=IDLE, byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rst_n_o=0, busy_o=0, done_o=0, err_o=0, words_o=0.
REQ-037 A reset during LOAD abandons the partial word without writing it; a new start_i is required after release.

Verification
REQ-038 Reset released, no start for 10 cycles -> all outputs stay at reset values; byte_valid_i pulses are ignored.
REQ-039 Start, then 8 bytes 30 F0 0A 00 00 00 00 00 with last on byte 8 -> one write at addr 0, data 0x00000000000AF030; done_o=1 and cpu_rst_n_o=1 the next cycle; words_o=1.
REQ-040 Start, then 11 bytes 01..0B with last on byte 11 -> two writes: addr 0 data 0x0807060504030201, addr 1 data 0x00000000000B0A09; words_o=2.
REQ-041 Same 11 bytes with byte_valid_i deasserted every other cycle -> identical writes and data; byte_ready_o stays 1 throughout LOAD.
REQ-042 ADDR_W=2, 33 bytes without last -> 4 writes (addr 0..3); the 33rd byte causes err_o=1 with no write; cpu_rst_n_o stays 0; a later start_i returns to LOAD.
REQ-043 rst_n_i pulsed low mid-word (after 5 bytes) -> asynchronous return to IDLE with no write; a subsequent 8-byte load writes addr 0.
